// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: shared opcodes, ALU operation codes, immediate formats and index helper for the decode stage
package rv_decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;

    typedef enum logic [3:0] {
        ALU_ADD      = 4'd0,
        ALU_SLL      = 4'd1,
        ALU_SLT      = 4'd2,
        ALU_SLTU     = 4'd3,
        ALU_XOR      = 4'd4,
        ALU_SRL      = 4'd5,
        ALU_OR       = 4'd6,
        ALU_AND      = 4'd7,
        ALU_SUB      = 4'd8,
        ALU_SRA      = 4'd13,
        ALU_PASS_IMM = 4'd15
    } aluop_e;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

    function automatic logic idx_ok(input logic [4:0] r, input int nreg);
        return int'(r) < nreg;
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// rv_regfile: NREG x XLEN register file, two async read ports, one write port, optional write-to-read bypass
// Ports: clk, reset (async, active-high, clears all entries); we/wa/wd write port;
//        ra1/rd1 and ra2/rd2 read ports. x0 and out-of-range indices read 0.
module rv_regfile
    import rv_decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic [4:0]      ra1,
    output logic [XLEN-1:0] rd1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd2
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] mem_q [NREG];
    logic            wr;

    assign wr = we && wa != 5'd0 && idx_ok(wa, NREG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else if (wr) begin
            mem_q[wa[AW-1:0]] <= wd;
        end
    end

    always_comb begin
        rd1 = (ra1 == 5'd0 || !idx_ok(ra1, NREG)) ? '0 :
              (BYPASS != 0 && wr && wa == ra1) ? wd : mem_q[ra1[AW-1:0]];
        rd2 = (ra2 == 5'd0 || !idx_ok(ra2, NREG)) ? '0 :
              (BYPASS != 0 && wr && wa == ra2) ? wd : mem_q[ra2[AW-1:0]];
    end

endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: pipelined RV32I decoder with register-file read and a one-deep valid/ready output register
// Ports: clk, reset (async, active-high); in_valid/in_ready/komut from fetch; wb_en/wb_rd/wb_data writeback;
//        out_valid/out_ready to execute; opcode, aluop, rs1, rs2, rd, rs1_data, rs2_data, imm, hata, err_count.
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    parameter int ERRW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     komut,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      opcode,
    output logic [3:0]      aluop,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm,
    output logic            hata,
    output logic [ERRW-1:0] err_count
);

    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    imm_fmt_e        fmt;
    logic            use1, use2, used, legal;
    logic [3:0]      alu_c;
    logic [4:0]      rs1_c, rs2_c, rd_c;
    logic            hata_c;
    logic [XLEN-1:0] imm_c, rf1, rf2, dat1, dat2;
    logic            load, stall, wb_ok;

    logic            valid_q, valid_d;
    logic [6:0]      opcode_q, opcode_d;
    logic [3:0]      aluop_q, aluop_d;
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic            hata_q, hata_d;
    logic [ERRW-1:0] err_q, err_d;

    assign opc = komut[6:0];
    assign f3  = komut[14:12];
    assign f7  = komut[31:25];

    always_comb begin
        fmt   = FMT_R;
        legal = 1'b1;
        use1  = 1'b0;
        use2  = 1'b0;
        used  = 1'b0;
        alu_c = ALU_ADD;
        case (opc)
            OP_OP: begin
                use1  = 1'b1;
                use2  = 1'b1;
                used  = 1'b1;
                alu_c = {f7[5], f3};
                legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
            end
            OP_IMM: begin
                fmt   = FMT_I;
                use1  = 1'b1;
                used  = 1'b1;
                // funct7[5] only selects SRAI; for other funct3 those bits are immediate
                alu_c = {f3 == 3'b101 && f7[5], f3};
                legal = f3 == 3'b001 ? f7 == 7'h00 :
                        f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            end
            OP_LOAD, OP_JALR: begin
                fmt  = FMT_I;
                use1 = 1'b1;
                used = 1'b1;
            end
            OP_STORE: begin
                fmt  = FMT_S;
                use1 = 1'b1;
                use2 = 1'b1;
            end
            OP_BRANCH: begin
                fmt   = FMT_B;
                use1  = 1'b1;
                use2  = 1'b1;
                alu_c = ALU_SUB;
            end
            OP_LUI: begin
                fmt   = FMT_U;
                used  = 1'b1;
                alu_c = ALU_PASS_IMM;
            end
            OP_AUIPC: begin
                fmt  = FMT_U;
                used = 1'b1;
            end
            OP_JAL: begin
                fmt  = FMT_J;
                used = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        rs1_c  = use1 ? komut[19:15] : 5'd0;
        rs2_c  = use2 ? komut[24:20] : 5'd0;
        rd_c   = used ? komut[11:7] : 5'd0;
        hata_c = !legal || !idx_ok(rs1_c, NREG) || !idx_ok(rs2_c, NREG) || !idx_ok(rd_c, NREG);
        imm_c  = fmt == FMT_I ? XLEN'($signed(komut[31:20])) :
                 fmt == FMT_S ? XLEN'($signed({komut[31:25], komut[11:7]})) :
                 fmt == FMT_B ? XLEN'($signed({komut[31], komut[7], komut[30:25], komut[11:8], 1'b0})) :
                 fmt == FMT_U ? XLEN'($signed({komut[31:12], 12'b0})) :
                 fmt == FMT_J ? XLEN'($signed({komut[31], komut[19:12], komut[20], komut[30:21], 1'b0})) : '0;
        dat1   = hata_c ? '0 : rf1;
        dat2   = hata_c ? '0 : rf2;
    end

    rv_regfile #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .BYPASS(BYPASS)
    ) u_rf (
        .clk  (clk),
        .reset(reset),
        .we   (wb_en),
        .wa   (wb_rd),
        .wd   (wb_data),
        .ra1  (rs1_c),
        .rd1  (rf1),
        .ra2  (rs2_c),
        .rd2  (rf2)
    );

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;
    assign stall    = valid_q && !out_ready;
    assign wb_ok    = wb_en && wb_rd != 5'd0 && idx_ok(wb_rd, NREG);

    always_comb begin
        valid_d    = in_ready ? in_valid : valid_q;
        opcode_d   = load ? opc : opcode_q;
        aluop_d    = load ? (hata_c ? 4'd0 : alu_c) : aluop_q;
        rs1_d      = load ? rs1_c : rs1_q;
        rs2_d      = load ? rs2_c : rs2_q;
        rd_d       = load ? rd_c : rd_q;
        imm_d      = load ? imm_c : imm_q;
        hata_d     = load ? hata_c : hata_q;
        // a held operand tracks writebacks to its register so it never goes stale while stalled
        rs1_data_d = load ? dat1 : (stall && wb_ok && !hata_q && rs1_q == wb_rd) ? wb_data : rs1_data_q;
        rs2_data_d = load ? dat2 : (stall && wb_ok && !hata_q && rs2_q == wb_rd) ? wb_data : rs2_data_q;
        err_d      = (load && hata_c && !(&err_q)) ? err_q + 1'b1 : err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            opcode_q   <= '0;
            aluop_q    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            hata_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            opcode_q   <= opcode_d;
            aluop_q    <= aluop_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            hata_q     <= hata_d;
            err_q      <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign opcode    = opcode_q;
    assign aluop     = aluop_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rd        = rd_q;
    assign rs1_data  = rs1_data_q;
    assign rs2_data  = rs2_data_q;
    assign imm       = imm_q;
    assign hata      = hata_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: two decode-stage configurations checked against a behavioural decode/regfile model
module tb_rv_decode_stage;

    typedef struct packed {
        logic [3:0]  alu;
        logic [4:0]  r1, r2, rd;
        logic [31:0] imm;
        logic        h;
    } dec_t;

    typedef struct packed {
        logic        v;
        logic [6:0]  op;
        logic [3:0]  alu;
        logic [4:0]  r1, r2, rd;
        logic [31:0] d1, d2, imm;
        logic        h;
    } out_t;

    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, wb_en = 1'b0;
    logic [31:0] komut = '0, wb_data = '0;
    logic [4:0]  wb_rd = '0;

    logic        ir_w [2], ov_w [2], h_w [2];
    logic [6:0]  op_w [2];
    logic [3:0]  alu_w [2];
    logic [4:0]  r1_w [2], r2_w [2], rd_w [2];
    logic [31:0] d1_w [2], d2_w [2], imm_w [2];
    logic [15:0] err_w [2];

    logic [31:0] mreg [2][32];
    out_t        mo [2];
    int          merr [2];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(32), .NREG(32), .BYPASS(1), .ERRW(16)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_w[0]), .komut(komut),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(ov_w[0]), .out_ready(out_ready),
        .opcode(op_w[0]), .aluop(alu_w[0]), .rs1(r1_w[0]), .rs2(r2_w[0]), .rd(rd_w[0]),
        .rs1_data(d1_w[0]), .rs2_data(d2_w[0]), .imm(imm_w[0]), .hata(h_w[0]), .err_count(err_w[0])
    );

    rv_decode_stage #(.XLEN(32), .NREG(16), .BYPASS(0), .ERRW(16)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_w[1]), .komut(komut),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(ov_w[1]), .out_ready(out_ready),
        .opcode(op_w[1]), .aluop(alu_w[1]), .rs1(r1_w[1]), .rs2(r2_w[1]), .rd(rd_w[1]),
        .rs1_data(d1_w[1]), .rs2_data(d2_w[1]), .imm(imm_w[1]), .hata(h_w[1]), .err_count(err_w[1])
    );

    task automatic chk(input int c, input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL c%0d %s act=%0h exp=%0h", c, n, a, e);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int b);
        logic [31:0] m = 32'd1 << (b - 1);
        return (v ^ m) - m;
    endfunction

    function automatic dec_t decode(input logic [31:0] k, input int nreg);
        dec_t        d = '0;
        logic [6:0]  f7 = k[31:25];
        int          f3 = int'(k[14:12]);
        logic        u1 = 1'b0, u2 = 1'b0, ud = 1'b0, ok = 1'b1;
        int          alu = 0;
        case (k[6:0])
            7'h33: begin
                u1 = 1; u2 = 1; ud = 1;
                alu = f3 + (f7[5] ? 8 : 0);
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            end
            7'h13: begin
                u1 = 1; ud = 1;
                d.imm = sx(k >> 20, 12);
                alu = f3 + ((f3 == 5 && f7[5]) ? 8 : 0);
                if (f3 == 1) ok = f7 == 7'h00;
                if (f3 == 5) ok = f7 == 7'h00 || f7 == 7'h20;
            end
            7'h03, 7'h67: begin u1 = 1; ud = 1; d.imm = sx(k >> 20, 12); end
            7'h23: begin u1 = 1; u2 = 1; d.imm = sx(((k >> 25) << 5) | ((k >> 7) & 31), 12); end
            7'h63: begin
                u1 = 1; u2 = 1; alu = 8;
                d.imm = sx((((k >> 31) & 1) << 12) | (((k >> 7) & 1) << 11) |
                           (((k >> 25) & 63) << 5) | (((k >> 8) & 15) << 1), 13);
            end
            7'h37: begin ud = 1; alu = 15; d.imm = k & 32'hFFFFF000; end
            7'h17: begin ud = 1; d.imm = k & 32'hFFFFF000; end
            7'h6F: begin
                ud = 1;
                d.imm = sx((((k >> 31) & 1) << 20) | (((k >> 12) & 255) << 12) |
                           (((k >> 20) & 1) << 11) | (((k >> 21) & 1023) << 1), 21);
            end
            default: ok = 0;
        endcase
        d.r1 = u1 ? k[19:15] : 5'd0;
        d.r2 = u2 ? k[24:20] : 5'd0;
        d.rd = ud ? k[11:7] : 5'd0;
        if (int'(d.r1) >= nreg || int'(d.r2) >= nreg || int'(d.rd) >= nreg) ok = 0;
        d.h = !ok;
        d.alu = ok ? 4'(alu) : 4'd0;
        return d;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 32; i++) mreg[c][i] = '0;
            mo[c] = '0;
            merr[c] = 0;
        end
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            int   nreg = c == 0 ? 32 : 16;
            logic byp = c == 0;
            logic wok = wb_en && wb_rd != 0 && int'(wb_rd) < nreg;
            dec_t d = decode(komut, nreg);
            if (!mo[c].v || out_ready) begin
                if (in_valid) begin
                    mo[c].v = 1; mo[c].op = komut[6:0]; mo[c].alu = d.alu;
                    mo[c].r1 = d.r1; mo[c].r2 = d.r2; mo[c].rd = d.rd; mo[c].imm = d.imm; mo[c].h = d.h;
                    mo[c].d1 = d.h ? 0 : (byp && wok && d.r1 != 0 && wb_rd == d.r1) ? wb_data : mreg[c][d.r1];
                    mo[c].d2 = d.h ? 0 : (byp && wok && d.r2 != 0 && wb_rd == d.r2) ? wb_data : mreg[c][d.r2];
                    if (d.h && merr[c] < 65535) merr[c]++;
                end else mo[c].v = 0;
            end else if (wok && !mo[c].h) begin
                if (mo[c].r1 == wb_rd) mo[c].d1 = wb_data;
                if (mo[c].r2 == wb_rd) mo[c].d2 = wb_data;
            end
            if (wok) mreg[c][wb_rd] = wb_data;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                chk(c, "in_ready", ir_w[c], !mo[c].v || out_ready);
                chk(c, "out_valid", ov_w[c], mo[c].v);
                chk(c, "err_count", err_w[c], merr[c]);
                if (mo[c].v) begin
                    chk(c, "opcode", op_w[c], mo[c].op);
                    chk(c, "aluop", alu_w[c], mo[c].alu);
                    chk(c, "rs1", r1_w[c], mo[c].r1);
                    chk(c, "rs2", r2_w[c], mo[c].r2);
                    chk(c, "rd", rd_w[c], mo[c].rd);
                    chk(c, "rs1_data", d1_w[c], mo[c].d1);
                    chk(c, "rs2_data", d2_w[c], mo[c].d2);
                    chk(c, "imm", imm_w[c], mo[c].imm);
                    chk(c, "hata", h_w[c], mo[c].h);
                end
            end
        end
    end

    task automatic go();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] k, input logic orr,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd);
        in_valid = iv; komut = k; out_ready = orr; wb_en = we; wb_rd = wr; wb_data = wd;
    endtask

    function automatic logic [31:0] rnd_komut();
        logic [31:0] k = $urandom;
        logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        int          s = $urandom_range(0, 9);
        int          f = $urandom_range(0, 2);
        if (s < 9) k[6:0] = ops[s];
        if (k[6:0] == 7'h33 || k[6:0] == 7'h13) k[31:25] = f == 0 ? 7'h00 : f == 1 ? 7'h20 : k[31:25];
        return k;
    endfunction

    initial begin
        logic [31:0] k;
        model_reset();
        go();
        go();
        reset = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            chk(c, "rst_valid", ov_w[c], 0);
            chk(c, "rst_err", err_w[c], 0);
            chk(c, "rst_imm", imm_w[c], 0);
            chk(c, "rst_rd", rd_w[c], 0);
            chk(c, "rst_data", d1_w[c], 0);
            chk(c, "rst_ready", ir_w[c], 1);
        end

        drive(1, 32'h00500093, 1, 0, 0, 0); go();
        for (int c = 0; c < 2; c++) begin
            chk(c, "addi_valid", ov_w[c], 1);
            chk(c, "addi_op", op_w[c], 7'h13);
            chk(c, "addi_rd", rd_w[c], 1);
            chk(c, "addi_rs1", r1_w[c], 0);
            chk(c, "addi_imm", imm_w[c], 5);
            chk(c, "addi_alu", alu_w[c], 0);
            chk(c, "addi_hata", h_w[c], 0);
        end

        drive(0, 0, 1, 1, 1, 7); go();
        drive(0, 0, 1, 1, 2, 9); go();
        drive(1, 32'h002081B3, 1, 0, 0, 0); go();
        for (int c = 0; c < 2; c++) begin
            chk(c, "add_d1", d1_w[c], 7);
            chk(c, "add_d2", d2_w[c], 9);
            chk(c, "add_rd", rd_w[c], 3);
            chk(c, "add_alu", alu_w[c], 0);
        end
        drive(1, 32'h002081B3, 1, 1, 1, 32'h55); go();
        chk(0, "bypass_d1", d1_w[0], 32'h55);
        chk(1, "nobypass_d1", d1_w[1], 7);

        drive(1, 32'h407302B3, 1, 0, 0, 0); go();
        for (int c = 0; c < 2; c++) chk(c, "sub_alu", alu_w[c], 8);
        drive(1, 32'h12345537, 1, 0, 0, 0); go();
        for (int c = 0; c < 2; c++) begin
            chk(c, "lui_imm", imm_w[c], 32'h12345000);
            chk(c, "lui_alu", alu_w[c], 15);
        end

        drive(1, 32'h00000001, 1, 0, 0, 0); go();
        for (int c = 0; c < 2; c++) begin
            chk(c, "ill_hata", h_w[c], 1);
            chk(c, "ill_valid", ov_w[c], 1);
            chk(c, "ill_err", err_w[c], 1);
        end
        drive(1, 32'h00100893, 1, 0, 0, 0); go();
        chk(0, "x17_hata", h_w[0], 0);
        chk(0, "x17_err", err_w[0], 1);
        chk(1, "x17_hata", h_w[1], 1);
        chk(1, "x17_err", err_w[1], 2);

        drive(1, 32'h002081B3, 1, 0, 0, 0); go();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h407302B3, 0, i == 2, 2, 32'hAA);
            #1;
            for (int c = 0; c < 2; c++) chk(c, "stall_ready", ir_w[c], 0);
            go();
            for (int c = 0; c < 2; c++) begin
                chk(c, "stall_valid", ov_w[c], 1);
                chk(c, "stall_rd", rd_w[c], 3);
                chk(c, "stall_d1", d1_w[c], 32'h55);
                chk(c, "stall_d2", d2_w[c], i >= 2 ? 32'hAA : 32'h9);
            end
        end
        drive(1, 32'h12345537, 1, 0, 0, 0);
        #1;
        for (int c = 0; c < 2; c++) chk(c, "release_ready", ir_w[c], 1);
        go();
        for (int c = 0; c < 2; c++) chk(c, "release_rd", rd_w[c], 10);

        drive(0, 0, 1, 1, 0, 32'hFF); go();
        drive(1, 32'h000001B3, 1, 0, 0, 0); go();
        for (int c = 0; c < 2; c++) begin
            chk(c, "x0_d1", d1_w[c], 0);
            chk(c, "x0_d2", d2_w[c], 0);
        end

        drive(1, 32'h002081B3, 1, 0, 0, 0); go();
        drive(0, 0, 0, 0, 0, 0); go();
        reset = 1'b1;
        #1;
        for (int c = 0; c < 2; c++) chk(c, "midstall_rst_valid", ov_w[c], 0);
        go();
        reset = 1'b0;
        for (int r = 1; r < 32; r++) begin
            drive(1, (32'(r) << 20) | (32'(r) << 15) | 32'h000001B3, 1, 0, 0, 0); go();
            chk(0, "rf_clear_d1", d1_w[0], 0);
            chk(0, "rf_clear_d2", d2_w[0], 0);
        end

        for (int i = 0; i < 3000; i++) begin
            k = rnd_komut();
            drive($urandom_range(0, 3) != 0, k, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1) == 1) ? k[19:15] : 5'($urandom), $urandom);
            go();
        end

        for (int i = 0; i < 70000; i++) begin
            drive(1, 32'h00000001, 1, 0, 0, 0); go();
        end
        for (int c = 0; c < 2; c++) chk(c, "err_sat", err_w[c], 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
